// File: rtl/zero_flag_gen_if.sv
// Bus between register-file read ports and the branch zero-flag generator.
// master drives the request side; slave returns busy/valid and the flags.
interface zero_flag_gen_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic             zero;
  logic             lt;

  modport master (
    output start, mode, a, b,
    input  busy, valid, zero, lt
  );

  modport slave (
    input  start, mode, a, b,
    output busy, valid, zero, lt
  );
endinterface

// File: rtl/zero_flag_gen.sv
// Multi-cycle branch flag generator: chunked LSB-first subtract of a-b (or a-0),
// reporting zero and signed less-than with a start/busy/valid handshake.
module zero_flag_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  zero_flag_gen_if.slave  bus
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % CHUNK) != 0 || N < 1) begin : g_bad_params
    $error("zero_flag_gen: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              borrow_q, borrow_d;
  logic              nz_q, nz_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              zero_q, zero_d;
  logic              lt_q, lt_d;

  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [CHUNK:0]    chunk_res;
  logic              d_msb;
  logic              ovf;

  // One chunk of the subtract; bit CHUNK of the result is the borrow-out.
  always_comb begin
    chunk_a   = a_q[idx_q*CHUNK +: CHUNK];
    chunk_b   = b_q[idx_q*CHUNK +: CHUNK];
    chunk_res = {1'b0, chunk_a} - {1'b0, chunk_b} - {{CHUNK{1'b0}}, borrow_q};
  end

  always_comb begin
    d_msb = diff_q[WIDTH-1];
    ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_msb != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    nz_d     = nz_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    zero_d   = zero_q;
    lt_d     = lt_q;

    unique case (state_q)
      StIdle: begin
        // busy_q may still be high here: this is the valid cycle of the previous
        // compare, which is also the earliest cycle a new start is taken.
        busy_d = 1'b0;
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.mode ? '0 : bus.b;
          diff_d   = '0;
          idx_d    = '0;
          borrow_d = 1'b0;
          nz_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end

      StRun: begin
        diff_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        nz_d     = nz_q | (|chunk_res[CHUNK-1:0]);
        borrow_d = chunk_res[CHUNK];
        if (idx_q == IdxW'(N - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StDone: begin
        // Top-chunk borrow is dropped; signed order comes from sign and overflow.
        zero_d  = ~nz_q;
        lt_d    = d_msb ^ ovf;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      nz_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      nz_q     <= nz_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.zero  = zero_q;
  assign bus.lt    = lt_q;

endmodule

// File: tb/tb_zero_flag_gen.sv
// Directed bench for zero_flag_gen: default CHUNK=8 instance plus a CHUNK=32 instance.
module tb_zero_flag_gen;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic prev_zero;
  logic prev_lt;

  zero_flag_gen_if #(.WIDTH(32)) bus0 ();
  zero_flag_gen_if #(.WIDTH(32)) bus1 ();

  zero_flag_gen #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  zero_flag_gen #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one compare on dut0 and follow it to its valid pulse; flags must hold
  // until then. With poke set, a stray start is pulsed while busy.
  task automatic run_cmp(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tm, input logic ez, input logic el, input bit poke);
    int  k;
    bit  got;
    bus0.start = 1'b1;
    bus0.a     = ta;
    bus0.b     = tb_v;
    bus0.mode  = tm;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus0.a     = ~ta;
    bus0.b     = ~tb_v;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      k++;
      bus0.start = (poke && k == 2);
      @(posedge clk);
      #1;
      if (bus0.valid === 1'b1) begin
        got = 1'b1;
      end else begin
        chk({tag, "_hold_zero"}, {31'b0, bus0.zero}, {31'b0, prev_zero});
        chk({tag, "_hold_lt"}, {31'b0, bus0.lt}, {31'b0, prev_lt});
        chk({tag, "_busy"}, {31'b0, bus0.busy}, 32'd1);
      end
    end
    bus0.start = 1'b0;
    chk({tag, "_latency"}, k, 32'd5);
    chk({tag, "_zero"}, {31'b0, bus0.zero}, {31'b0, ez});
    chk({tag, "_lt"}, {31'b0, bus0.lt}, {31'b0, el});
    chk({tag, "_busy_vcyc"}, {31'b0, bus0.busy}, 32'd1);
    prev_zero = ez;
    prev_lt   = el;
  endtask

  initial begin
    int cnt;
    total      = 0;
    bad        = 0;
    prev_zero  = 1'b0;
    prev_lt    = 1'b0;
    reset      = 1'b1;
    bus0.start = 1'b0;
    bus0.mode  = 1'b0;
    bus0.a     = '0;
    bus0.b     = '0;
    bus1.start = 1'b0;
    bus1.mode  = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus0.busy}, 32'd0);
    chk("rst_valid", {31'b0, bus0.valid}, 32'd0);
    chk("rst_zero", {31'b0, bus0.zero}, 32'd0);
    chk("rst_lt", {31'b0, bus0.lt}, 32'd0);
    reset = 1'b0;

    // Reset mid-RUN aborts the compare with no valid.
    bus0.start = 1'b1;
    bus0.a     = 32'd5;
    bus0.b     = 32'd5;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_pre", {31'b0, bus0.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, bus0.busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus0.valid === 1'b1) cnt++;
    end
    chk("abort_no_valid", cnt, 32'd0);
    chk("abort_zero", {31'b0, bus0.zero}, 32'd0);
    chk("abort_lt", {31'b0, bus0.lt}, 32'd0);

    run_cmp("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cmp("ovf_neg_pos", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cmp("ovf_pos_neg", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cmp("tz_zero", 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_cmp("tz_neg", 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_cmp("borrow_ge", 32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cmp("borrow_lt", 32'h0000_0100, 32'h0000_0101, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cmp("both_zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Stray start while busy must neither disturb the result nor queue a compare.
    run_cmp("poke", 32'h0000_0100, 32'h0000_0101, 1'b0, 1'b0, 1'b1, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus0.valid === 1'b1) cnt++;
    end
    chk("poke_no_extra", cnt, 32'd0);

    // Back-to-back: second start issued in the valid cycle of the first.
    run_cmp("b2b_first", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cmp("b2b_second", 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_valid_drop", {31'b0, bus0.valid}, 32'd0);
    chk("b2b_busy_drop", {31'b0, bus0.busy}, 32'd0);

    // Single-chunk instance: valid two edges after accept.
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a     = 32'h8000_0000;
    bus1.b     = 32'h7FFF_FFFF;
    bus1.mode  = 1'b0;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus1.a     = 32'd0;
    @(posedge clk);
    #1;
    chk("c32_valid_early", {31'b0, bus1.valid}, 32'd0);
    chk("c32_busy", {31'b0, bus1.busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("c32_valid", {31'b0, bus1.valid}, 32'd1);
    chk("c32_zero", {31'b0, bus1.zero}, 32'd0);
    chk("c32_lt", {31'b0, bus1.lt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
